cpu_mem_arbiter: RTL

CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

---
 rtl/lc3b_types.sv | 6 +
 rtl/arb_wait_counter.sv | 18 +
 rtl/cpu_mem_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// lc3b_types: shared word type, arbiter state encoding and default timeout
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef enum logic [1:0] {IDLE, I_ACCESS, D_ACCESS, RECOVER} arb_state_t;
  localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: counts wait cycles, raises tc_o once LIMIT cycles have elapsed
module arb_wait_counter #(
  parameter int unsigned W     = 16,
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign tc_o = cnt_q == W'(LIMIT);
  always_comb cnt_d = clr_i ? '0 : (en_i && !tc_o) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one physical memory between instruction and data ports
// ARB_FAIR_EN: alternate grants when both ports pend; otherwise data has fixed priority
module cpu_mem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_mem_read,
  input  logic       i_mem_write,
  input  lc3b_word   i_mem_address,
  input  lc3b_word   i_mem_wdata,
  input  logic [1:0] i_mem_byte_enable,
  output logic       i_mem_resp,
  output lc3b_word   i_mem_rdata,
  input  logic       d_mem_read,
  input  logic       d_mem_write,
  input  lc3b_word   d_mem_address,
  input  lc3b_word   d_mem_wdata,
  input  logic [1:0] d_mem_byte_enable,
  output logic       d_mem_resp,
  output lc3b_word   d_mem_rdata,
  output logic       pmem_read,
  output logic       pmem_write,
  output lc3b_word   pmem_address,
  output lc3b_word   pmem_wdata,
  output logic [1:0] pmem_byte_enable,
  input  logic       pmem_resp,
  input  lc3b_word   pmem_rdata,
  output logic       timeout_err
);
  arb_state_t state_q, state_d;
  lc3b_word   addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0] be_q, be_d;
  logic       wr_q, wr_d;
  logic       d_pend, i_pend, pick_d, access, tc, done;
`ifdef ARB_FAIR_EN
  logic       last_q, last_d;
`endif

  assign d_pend = d_mem_read | d_mem_write;
  assign i_pend = i_mem_read | i_mem_write;
`ifdef ARB_FAIR_EN
  assign pick_d = d_pend && (!i_pend || !last_q);
`else
  assign pick_d = d_pend;
`endif
  assign access = (state_q == I_ACCESS) || (state_q == D_ACCESS);
  assign done   = access && (pmem_resp || tc);

  arb_wait_counter #(.W(16), .LIMIT(TIMEOUT_CYCLES)) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (!access),
    .en_i  (access && !pmem_resp),
    .tc_o  (tc)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
`ifdef ARB_FAIR_EN
    last_d  = last_q;
`endif
    if (state_q == IDLE && (d_pend || i_pend)) begin
      state_d = pick_d ? D_ACCESS : I_ACCESS;
      addr_d  = pick_d ? d_mem_address : i_mem_address;
      wdata_d = pick_d ? d_mem_wdata : i_mem_wdata;
      be_d    = pick_d ? d_mem_byte_enable : i_mem_byte_enable;
      wr_d    = pick_d ? d_mem_write : i_mem_write;
`ifdef ARB_FAIR_EN
      last_d  = pick_d;
`endif
    end else if (done) begin
      state_d = RECOVER;
    end else if (state_q == RECOVER) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
`ifdef ARB_FAIR_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
`ifdef ARB_FAIR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign pmem_read        = access && !wr_q;
  assign pmem_write       = access && wr_q;
  assign pmem_address     = access ? addr_q : '0;
  assign pmem_wdata       = access ? wdata_q : '0;
  assign pmem_byte_enable = access ? be_q : '0;
  assign i_mem_resp       = (state_q == I_ACCESS) && done;
  assign d_mem_resp       = (state_q == D_ACCESS) && done;
  // a timed-out access completes with zero data
  assign i_mem_rdata      = (i_mem_resp && pmem_resp) ? pmem_rdata : '0;
  assign d_mem_rdata      = (d_mem_resp && pmem_resp) ? pmem_rdata : '0;
  assign timeout_err      = access && tc && !pmem_resp;
endmodule
